alu_issue_ctrl: RTL

// - Issue-side controller for the RV32 integer ALU: accepts a decoded-stage instruction plus rs1/rs2 values over valid/ready.
// - Generates the ALU select code and operands, samples the combinational ALU result, and returns it with the rd tag over valid/ready.
// - Sits between the register-read stage and the combinational ALU. Supported ops: ADD/SUB/OR/AND (R-type), ADDI/ORI/ANDI (I-type).

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/alu_sel_decode.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32 ALU issue path.
package alu_pkg;

    // Opcodes handled by the integer ALU
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // funct3 values for the supported operations
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // funct7 values accepted on R-type
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU select codes: [3] = subtract, [2:0] = op
    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b1000;
    localparam logic [3:0] SEL_OR  = 4'b0110;
    localparam logic [3:0] SEL_AND = 4'b0111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    function automatic logic [31:0] sext_imm12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between register-read, issue control and consumer.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_err;

    // Environment side: issues requests, consumes responses
    modport master (
        output in_valid, instr, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_err
    );

    // Controller side
    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_err
    );
endinterface

// File: rtl/alu_sel_decode.sv
// Combinational decode of an RV32 instruction into ALU select, immediate and legality.
module alu_sel_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  sel,
    output logic        use_imm,
    output logic [31:0] imm32,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r;
    logic       is_i;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_r   = (opcode == OPC_OP);
    assign is_i   = (opcode == OPC_OPIMM);

    // Register specifiers are carried by the caller, not needed for select decode
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    // Select/legality decode; illegal encodings always present SEL_ADD
    always_comb begin
        sel     = SEL_ADD;
        illegal = 1'b0;
        use_imm = is_i;
        imm32   = sext_imm12(instr[31:20]);
        if (!is_r && !is_i) begin
            illegal = 1'b1;
        end else begin
            case (funct3)
                F3_ADD:  sel = (is_r && instr[30]) ? SEL_SUB : SEL_ADD;
                F3_OR:   sel = SEL_OR;
                F3_AND:  sel = SEL_AND;
                default: illegal = 1'b1;
            endcase
            // funct7 only constrains R-type; I-type bit 30 is immediate data
            if (is_r && !(funct7 == F7_BASE || (funct7 == F7_ALT && funct3 == F3_ADD))) begin
                illegal = 1'b1;
            end
        end
        if (illegal) begin
            sel = SEL_ADD;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the external combinational RV32 ALU.
// Accepts one request, drives the ALU for EXEC_CYCLES, returns the result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_ctrl_if.slave    bus,
    output logic [3:0]         sel_alu,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [31:0]        alu_res,
    output logic [CNT_W-1:0]   op_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [31:0]      out_result_q;
    logic [4:0]       out_rd_q;
    logic             out_err_q;
    logic [3:0]       sel_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [3:0]       exec_q;
    logic [CNT_W-1:0] op_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [3:0]       dec_sel;
    logic             dec_use_imm;
    logic [31:0]      dec_imm;
    logic             dec_illegal;

    alu_sel_decode u_decode (
        .instr   (bus.instr),
        .sel     (dec_sel),
        .use_imm (dec_use_imm),
        .imm32   (dec_imm),
        .illegal (dec_illegal)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Request FSM with every output held in a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_err_q    <= 1'b0;
            sel_q        <= SEL_ADD;
            a_q          <= '0;
            b_q          <= '0;
            exec_q       <= '0;
            op_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        out_rd_q   <= bus.instr[11:7];
                        if (dec_illegal) begin
                            // Illegal requests skip the ALU entirely
                            out_err_q    <= 1'b1;
                            out_result_q <= '0;
                            out_valid_q  <= 1'b1;
                            err_cnt_q    <= sat_inc(err_cnt_q);
                            state_q      <= StResp;
                        end else begin
                            out_err_q <= 1'b0;
                            sel_q     <= dec_sel;
                            a_q       <= bus.rs1_val;
                            b_q       <= dec_use_imm ? dec_imm : bus.rs2_val;
                            exec_q    <= EXEC_LOAD;
                            state_q   <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (exec_q == 4'd0) begin
                        out_result_q <= alu_res;
                        out_valid_q  <= 1'b1;
                        op_cnt_q     <= sat_inc(op_cnt_q);
                        // ALU ports idle at zero outside EXEC
                        sel_q        <= SEL_ADD;
                        a_q          <= '0;
                        b_q          <= '0;
                        state_q      <= StResp;
                    end else begin
                        exec_q <= exec_q - 4'd1;
                    end
                end
                StResp: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_err    = out_err_q;
    assign sel_alu        = sel_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign op_cnt         = op_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule
